// File: rtl/wave_capture_multi.sv
// wave_capture_multi: trigger-aligned multi-channel frame capture into a
// ping-pong sample RAM. Optional input decimation: WAVE_CAPTURE_DECIMATE_EN.
module wave_capture_multi #(
    parameter int CH_BITS    = 1,
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_BITS = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 new_sample_ready,
    input  logic [(2**CH_BITS)*SAMPLE_W-1:0]     new_sample_in,
    input  logic [CH_BITS-1:0]                   trig_ch,
    input  logic [1:0]                           trig_mode,
    input  logic                                 arm,
`ifdef WAVE_CAPTURE_DECIMATE_EN
    input  logic [3:0]                           decim,
`endif
    input  logic                                 wave_display_idle,
    output logic [CH_BITS+DEPTH_BITS:0]          write_address,
    output logic                                 write_enable,
    output logic [OUT_W-1:0]                     write_sample,
    output logic                                 read_index,
    output logic                                 overrun
);

    localparam int NUM_CH = 2**CH_BITS;
    localparam logic [OUT_W-1:0] FLIP = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [DEPTH_BITS-1:0] LAST_IDX = '1;
    localparam logic [CH_BITS-1:0] LAST_CH = '1;
    localparam logic [CH_BITS:0] CNT_INIT = (CH_BITS+1)'(NUM_CH);

    typedef enum logic [1:0] {
        S_ARMED,
        S_ACTIVE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                    state_q;
    logic [NUM_CH*OUT_W-1:0]   samp_q;
    logic [CH_BITS:0]          cnt_q;
    logic [CH_BITS-1:0]        ch_q;
    logic [DEPTH_BITS-1:0]     idx_q;
    logic                      prev_valid_q;
    logic                      prev_neg_q;
    logic [1:0]                frame_mode_q;
    logic                      we_q;
    logic [CH_BITS+DEPTH_BITS:0] waddr_q;
    logic [OUT_W-1:0]          wsamp_q;
    logic                      rd_idx_q;
    logic                      ovr_q;

    logic                      pulse;
    logic                      busy;
    logic                      capturing;
    logic                      take;
    logic                      drop;
    logic                      trig_hit;
    logic                      start_wr;
    logic                      cur_neg;
    logic                      enter_armed;
    logic [NUM_CH*OUT_W-1:0]   top_in;

`ifdef WAVE_CAPTURE_DECIMATE_EN
    logic [3:0] dec_q;
    logic       dec_hit;

    assign dec_hit = (dec_q == decim);
    assign pulse   = new_sample_ready && dec_hit;

    // Count raw pulses; only every (decim+1)-th one is passed on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_q <= '0;
        end else if (enter_armed) begin
            dec_q <= '0;
        end else if (new_sample_ready) begin
            dec_q <= dec_hit ? 4'd0 : dec_q + 4'd1;
        end
    end
`else
    assign pulse = new_sample_ready;
`endif

    assign busy      = (cnt_q != '0);
    assign capturing = (state_q == S_ARMED) || (state_q == S_ACTIVE);
    assign take      = pulse && !busy && capturing;
    assign drop      = pulse && busy && capturing;
    assign start_wr  = take && ((state_q == S_ACTIVE) || trig_hit);
    assign cur_neg   = new_sample_in[int'(trig_ch)*SAMPLE_W + SAMPLE_W - 1];

    assign enter_armed =
        ((state_q == S_WAIT) && wave_display_idle && (frame_mode_q != 2'b11)) ||
        ((state_q == S_HOLD) && arm);

    // Truncate each channel to its top OUT_W bits and convert to offset binary.
    always_comb begin
        top_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            top_in[k*OUT_W +: OUT_W] =
                new_sample_in[k*SAMPLE_W + SAMPLE_W - 1 -: OUT_W] ^ FLIP;
        end
    end

    // Sign-crossing trigger on the watched channel; free-run always fires.
    always_comb begin
        trig_hit = 1'b0;
        unique case (trig_mode)
            2'b00, 2'b11: trig_hit = prev_valid_q && prev_neg_q && !cur_neg;
            2'b01:        trig_hit = prev_valid_q && !prev_neg_q && cur_neg;
            2'b10:        trig_hit = 1'b1;
        endcase
    end

    // Capture FSM, channel serializer and registered RAM write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_ARMED;
            samp_q       <= '0;
            cnt_q        <= '0;
            ch_q         <= '0;
            idx_q        <= '0;
            prev_valid_q <= 1'b0;
            prev_neg_q   <= 1'b0;
            frame_mode_q <= 2'b00;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wsamp_q      <= '0;
            rd_idx_q     <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (arm) begin
                ovr_q <= 1'b0;
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end
            if (busy) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (busy && (ch_q != '0)) begin
                we_q    <= 1'b1;
                waddr_q <= {~rd_idx_q, ch_q, idx_q};
                wsamp_q <= samp_q[int'(ch_q)*OUT_W +: OUT_W];
                ch_q    <= ch_q + 1'b1;
                if (ch_q == LAST_CH) begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_WAIT;
                    end
                end
            end
            unique case (state_q)
                S_ARMED: begin
                    if (take) begin
                        prev_neg_q   <= cur_neg;
                        prev_valid_q <= 1'b1;
                        if (trig_hit) begin
                            state_q      <= S_ACTIVE;
                            frame_mode_q <= trig_mode;
                        end
                    end
                end
                S_ACTIVE: ;
                S_WAIT: begin
                    if (wave_display_idle) begin
                        rd_idx_q <= ~rd_idx_q;
                        state_q  <= (frame_mode_q == 2'b11) ? S_HOLD : S_ARMED;
                    end
                end
                S_HOLD: begin
                    if (arm) begin
                        state_q <= S_ARMED;
                    end
                end
            endcase
            if (enter_armed) begin
                prev_valid_q <= 1'b0;
            end
            if (start_wr) begin
                samp_q  <= top_in;
                cnt_q   <= CNT_INIT;
                ch_q    <= CH_BITS'(1);
                we_q    <= 1'b1;
                waddr_q <= {~rd_idx_q, {CH_BITS{1'b0}}, idx_q};
                wsamp_q <= top_in[OUT_W-1:0];
            end
        end
    end

    assign write_address = waddr_q;
    assign write_enable  = we_q;
    assign write_sample  = wsamp_q;
    assign read_index    = rd_idx_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_wave_capture_multi.sv
// tb_wave_capture_multi: directed checks of trigger modes, frame fill,
// ping-pong flip, overrun and single-shot hold for wave_capture_multi.
module tb_wave_capture_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_sample_ready = 1'b0;
    logic [31:0] new_sample_in = '0;
    logic        trig_ch = 1'b0;
    logic [1:0]  trig_mode = 2'b00;
    logic        arm = 1'b0;
    logic        wave_display_idle = 1'b0;
`ifdef WAVE_CAPTURE_DECIMATE_EN
    logic [3:0]  decim = 4'd0;
`endif
    logic [9:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        overrun;

    int n_total = 0;
    int n_pass  = 0;

    wave_capture_multi dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .trig_ch           (trig_ch),
        .trig_mode         (trig_mode),
        .arm               (arm),
`ifdef WAVE_CAPTURE_DECIMATE_EN
        .decim             (decim),
`endif
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    // One accepted-rate pulse; returns what the write port showed 1 and 2
    // cycles after the pulse cycle, and leaves the serializer idle.
    task automatic send(input logic [15:0] c0, input logic [15:0] c1,
                        output logic w0, output logic [9:0] a0,
                        output logic [7:0] d0, output logic w1,
                        output logic [9:0] a1, output logic [7:0] d1);
        @(posedge clk); #1;
        new_sample_in    = {c1, c0};
        new_sample_ready = 1'b1;
        @(posedge clk); #1;
        new_sample_ready = 1'b0;
        w0 = write_enable; a0 = write_address; d0 = write_sample;
        @(posedge clk); #1;
        w1 = write_enable; a1 = write_address; d1 = write_sample;
    endtask

    task automatic pulse_arm();
        @(posedge clk); #1; arm = 1'b1;
        @(posedge clk); #1; arm = 1'b0;
    endtask

    // Sends the rest of a frame starting at index 'start', checking both
    // channel writes at every index.
    task automatic fill(input logic half, input int start);
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1, v;
        for (int i = start; i < 256; i++) begin
            v = 8'(i);
            send({v, 8'h00}, {~v, 8'h55}, w0, a0, d0, w1, a1, d1);
            n_total++;
            if (w0 !== 1'b1 || a0 !== {half, 1'b0, v} || d0 !== (v ^ 8'h80))
                $display("FAIL fill_ch0 idx=%0d got we=%b addr=%h data=%h want addr=%h data=%h",
                         i, w0, a0, d0, {half, 1'b0, v}, v ^ 8'h80);
            else n_pass++;
            n_total++;
            if (w1 !== 1'b1 || a1 !== {half, 1'b1, v} || d1 !== ((~v) ^ 8'h80))
                $display("FAIL fill_ch1 idx=%0d got we=%b addr=%h data=%h want addr=%h data=%h",
                         i, w1, a1, d1, {half, 1'b1, v}, (~v) ^ 8'h80);
            else n_pass++;
        end
    endtask

    // In WAIT: samples ignored, no flip until idle, then flip next edge.
    task automatic flip(input logic want);
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        send(16'hFF00, 16'h0100, w0, a0, d0, w1, a1, d1);
        send(16'h0100, 16'h0100, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b0 || w1 !== 1'b0 || overrun !== 1'b0)
            $display("FAIL wait_ignore got we=%b%b ovr=%b want 00 0", w0, w1, overrun);
        else n_pass++;
        n_total++;
        if (read_index !== ~want)
            $display("FAIL wait_hold_index got %b want %b", read_index, ~want);
        else n_pass++;
        wave_display_idle = 1'b1;
        @(posedge clk); #1;
        wave_display_idle = 1'b0;
        n_total++;
        if (read_index !== want)
            $display("FAIL flip_index got %b want %b", read_index, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({write_enable, write_address, write_sample, read_index, overrun} !== 21'd0)
            $display("FAIL reset_held got we=%b addr=%h data=%h ri=%b ovr=%b want all 0",
                     write_enable, write_address, write_sample, read_index, overrun);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({write_enable, write_address, write_sample, read_index, overrun} !== 21'd0)
            $display("FAIL reset_release got we=%b addr=%h data=%h ri=%b ovr=%b want all 0",
                     write_enable, write_address, write_sample, read_index, overrun);
        else n_pass++;
        send(16'h0100, 16'h0000, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b0 || w1 !== 1'b0)
            $display("FAIL reset_first_pulse got we=%b%b want 00", w0, w1);
        else n_pass++;
    endtask

    task automatic test_rising();
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        trig_mode = 2'b00;
        send(16'hFF00, 16'h1111, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b0 || w1 !== 1'b0)
            $display("FAIL rise_neg_no_trig got we=%b%b want 00", w0, w1);
        else n_pass++;
        send(16'h0100, 16'hC0DE, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b1 || a0 !== 10'h200 || d0 !== 8'h81)
            $display("FAIL rise_trig_ch0 got we=%b addr=%h data=%h want 1 200 81", w0, a0, d0);
        else n_pass++;
        n_total++;
        if (w1 !== 1'b1 || a1 !== 10'h300 || d1 !== 8'h40)
            $display("FAIL rise_trig_ch1 got we=%b addr=%h data=%h want 1 300 40", w1, a1, d1);
        else n_pass++;
        fill(1'b1, 1);
        flip(1'b1);
    endtask

    task automatic test_falling();
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        trig_mode = 2'b01;
        send(16'hFF00, 16'h0000, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b0 || w1 !== 1'b0)
            $display("FAIL fall_first_no_trig got we=%b%b want 00", w0, w1);
        else n_pass++;
        send(16'h0100, 16'h0000, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b0 || w1 !== 1'b0)
            $display("FAIL fall_ignores_rise got we=%b%b want 00", w0, w1);
        else n_pass++;
        send(16'hFF00, 16'h7FFF, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b1 || a0 !== 10'h000 || d0 !== 8'h7F)
            $display("FAIL fall_trig_ch0 got we=%b addr=%h data=%h want 1 000 7f", w0, a0, d0);
        else n_pass++;
        n_total++;
        if (w1 !== 1'b1 || a1 !== 10'h100 || d1 !== 8'hFF)
            $display("FAIL fall_trig_ch1 got we=%b addr=%h data=%h want 1 100 ff", w1, a1, d1);
        else n_pass++;
        fill(1'b0, 1);
        flip(1'b0);
    endtask

    task automatic test_free_run_overrun();
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        trig_mode = 2'b10;
        send(16'h1234, 16'h8000, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b1 || a0 !== 10'h200 || d0 !== 8'h92)
            $display("FAIL free_ch0 got we=%b addr=%h data=%h want 1 200 92", w0, a0, d0);
        else n_pass++;
        n_total++;
        if (w1 !== 1'b1 || a1 !== 10'h300 || d1 !== 8'h00)
            $display("FAIL free_ch1 got we=%b addr=%h data=%h want 1 300 00", w1, a1, d1);
        else n_pass++;
        @(posedge clk); #1;
        new_sample_in    = {16'h7FFF, 16'h5600};
        new_sample_ready = 1'b1;
        @(posedge clk); #1;
        new_sample_in    = {16'hAAAA, 16'hAAAA};
        n_total++;
        if (write_enable !== 1'b1 || write_address !== 10'h201 || write_sample !== 8'hD6)
            $display("FAIL ovr_first_ch0 got we=%b addr=%h data=%h want 1 201 d6",
                     write_enable, write_address, write_sample);
        else n_pass++;
        @(posedge clk); #1;
        new_sample_ready = 1'b0;
        n_total++;
        if (write_enable !== 1'b1 || write_address !== 10'h301 || write_sample !== 8'hFF)
            $display("FAIL ovr_first_ch1 got we=%b addr=%h data=%h want 1 301 ff",
                     write_enable, write_address, write_sample);
        else n_pass++;
        n_total++;
        if (overrun !== 1'b1)
            $display("FAIL ovr_set got %b want 1", overrun);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (write_enable !== 1'b0 || overrun !== 1'b1)
            $display("FAIL ovr_dropped got we=%b ovr=%b want 0 1", write_enable, overrun);
        else n_pass++;
        pulse_arm();
        n_total++;
        if (overrun !== 1'b0)
            $display("FAIL ovr_arm_clear got %b want 0", overrun);
        else n_pass++;
        fill(1'b1, 2);
        flip(1'b1);
    endtask

    task automatic test_single_shot();
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        trig_mode = 2'b11;
        send(16'hFF00, 16'h0000, w0, a0, d0, w1, a1, d1);
        send(16'h0100, 16'h8000, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b1 || a0 !== 10'h000 || d0 !== 8'h81 || d1 !== 8'h00)
            $display("FAIL ss_trig got we=%b addr=%h d0=%h d1=%h want 1 000 81 00",
                     w0, a0, d0, d1);
        else n_pass++;
        fill(1'b0, 1);
        flip(1'b0);
        for (int i = 0; i < 3; i++) begin
            send(16'hFF00, 16'h0000, w0, a0, d0, w1, a1, d1);
            send(16'h0100, 16'h0000, w0, a0, d0, w1, a1, d1);
            n_total++;
            if (w0 !== 1'b0 || w1 !== 1'b0)
                $display("FAIL ss_hold_%0d got we=%b%b want 00", i, w0, w1);
            else n_pass++;
        end
        pulse_arm();
        send(16'hFF00, 16'h0000, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b0 || w1 !== 1'b0)
            $display("FAIL ss_rearm_first got we=%b%b want 00", w0, w1);
        else n_pass++;
        send(16'h0100, 16'h0000, w0, a0, d0, w1, a1, d1);
        n_total++;
        if (w0 !== 1'b1 || a0 !== 10'h200 || d0 !== 8'h81)
            $display("FAIL ss_recapture got we=%b addr=%h data=%h want 1 200 81", w0, a0, d0);
        else n_pass++;
    endtask

`ifdef WAVE_CAPTURE_DECIMATE_EN
    task automatic test_decimate();
        logic w0, w1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        decim = 4'd3;
        for (int blk = 1; blk <= 2; blk++) begin
            for (int p = 0; p < 3; p++) begin
                send(16'h2000, 16'h0000, w0, a0, d0, w1, a1, d1);
                n_total++;
                if (w0 !== 1'b0)
                    $display("FAIL decim_skip_%0d_%0d got we=%b want 0", blk, p, w0);
                else n_pass++;
            end
            send(16'h2000, 16'h0000, w0, a0, d0, w1, a1, d1);
            n_total++;
            if (w0 !== 1'b1 || a0 !== {2'b10, 8'(blk)})
                $display("FAIL decim_write_%0d got we=%b addr=%h want 1 %h",
                         blk, w0, a0, {2'b10, 8'(blk)});
            else n_pass++;
        end
        decim = 4'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_free_run_overrun();
        test_single_shot();
`ifdef WAVE_CAPTURE_DECIMATE_EN
        test_decimate();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
